// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   LEN_WORD : architectural data word width.
//   MDU_*    : op encodings presented on mult_div_unit.op.
//   mdu_state_t : sequencing states of the iterative datapath.
package mult_div_unit_pkg;

    localparam int LEN_WORD = 32;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_step.sv
// mdu_step: one radix-2 iteration of the unsigned multiply/divide datapath.
// Ports:
//   acc      in  2*LEN  current accumulator {upper, lower}
//   operand  in  LEN    multiplicand or divisor magnitude
//   is_div   in  1      1 = restoring divide step, 0 = shift-add multiply step
//   acc_next out 2*LEN  accumulator after this iteration
// Multiply: upper half accumulates, whole register shifts right; the
// multiplier is consumed from bit 0 while product bits fill from the top.
// Divide: {remainder, dividend} shifts left; quotient bits fill bit 0.
module mdu_step
    import mult_div_unit_pkg::*;
#(
    parameter int LEN = LEN_WORD
) (
    input  logic [2*LEN-1:0] acc,
    input  logic [LEN-1:0]   operand,
    input  logic             is_div,
    output logic [2*LEN-1:0] acc_next
);

    logic [LEN:0]   add_sum;
    logic [LEN:0]   rem_shift;
    logic [LEN-1:0] rem_diff;

    always_comb begin
        add_sum   = {1'b0, acc[2*LEN-1:LEN]} + ({(LEN+1){acc[0]}} & {1'b0, operand});
        rem_shift = {acc[2*LEN-1:LEN], acc[LEN-1]};
        // Only used when rem_shift >= operand, so the result fits in LEN bits.
        rem_diff  = rem_shift[LEN-1:0] - operand;
        if (is_div) begin
            if (rem_shift >= {1'b0, operand}) begin
                acc_next = {rem_diff, acc[LEN-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[LEN-1:0], acc[LEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc[LEN-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO.
// Ports:
//   clk, reset (async, active low)
//   flush    in  EX flush, aborts an in-flight operation
//   start    in  arithmetic MDU instruction valid in EX
//   op       in  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   num_1    in  rs operand,  num_2 in rt operand
//   rd_req   in  MFHI/MFLO valid in EX
//   wr_hi    in  MTHI valid,  wr_lo in MTLO valid,  wr_data in source value
//   hi, lo   out architectural HI/LO
//   busy     out operation in flight
//   done     out one-cycle pulse when HI/LO take a new result
//   stall    out hold IF/ID/EX while a dependent MDU instruction waits
//
// state | meaning
// IDLE  | waiting; accepts start or MTHI/MTLO
// RUN   | one radix-2 step per cycle, LEN cycles
// FIX   | sign correction and HI/LO write-back
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int LEN     = LEN_WORD,
    parameter int LEN_CNT = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic [LEN-1:0] num_1,
    input  logic [LEN-1:0] num_2,
    input  logic           rd_req,
    input  logic           wr_hi,
    input  logic           wr_lo,
    input  logic [LEN-1:0] wr_data,
    output logic [LEN-1:0] hi,
    output logic [LEN-1:0] lo,
    output logic           busy,
    output logic           done,
    output logic           stall
);

    mdu_state_t state_q, state_d;

    logic [2*LEN-1:0] acc_q, acc_next;
    logic [LEN-1:0]   operand_q;
    logic [LEN_CNT-1:0] cnt_q;
    logic             is_div_q, neg_res_q, neg_rem_q;
    logic [LEN-1:0]   hi_q, lo_q;
    logic             done_q;

    logic load, step_en, commit, wr_hi_en, wr_lo_en;
    logic neg_a, neg_b;
    logic [LEN-1:0]   mag_a, mag_b;
    logic [2*LEN-1:0] prod;
    logic [LEN-1:0]   res_hi, res_lo;

    // Signed ops work on magnitudes; the most negative value maps to 2^(LEN-1).
    always_comb begin
        neg_a = op[0] & num_1[LEN-1];
        neg_b = op[0] & num_2[LEN-1];
        mag_a = neg_a ? -num_1 : num_1;
        mag_b = neg_b ? -num_2 : num_2;
    end

    mdu_step #(.LEN(LEN)) u_step (
        .acc      (acc_q),
        .operand  (operand_q),
        .is_div   (is_div_q),
        .acc_next (acc_next)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        step_en  = 1'b0;
        commit   = 1'b0;
        wr_hi_en = 1'b0;
        wr_lo_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else if (!start && !flush) begin
                    // start wins over a coincident MTHI/MTLO
                    wr_hi_en = wr_hi;
                    wr_lo_en = wr_lo;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt_q == LEN_CNT'(LEN - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                commit  = !flush;
            end
            default: state_d = IDLE;
        endcase
    end

    // Remainder follows the dividend sign; quotient/product follow sign xor.
    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        if (is_div_q) begin
            res_lo = neg_res_q ? -acc_q[LEN-1:0] : acc_q[LEN-1:0];
            res_hi = neg_rem_q ? -acc_q[2*LEN-1:LEN] : acc_q[2*LEN-1:LEN];
        end else begin
            res_lo = prod[LEN-1:0];
            res_hi = prod[2*LEN-1:LEN];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= commit;
            if (load) begin
                acc_q     <= {{LEN{1'b0}}, mag_a};
                operand_q <= mag_b;
                cnt_q     <= '0;
                is_div_q  <= op[1];
                neg_res_q <= neg_a ^ neg_b;
                neg_rem_q <= neg_a;
            end else if (step_en) begin
                acc_q <= acc_next;
                cnt_q <= cnt_q + LEN_CNT'(1);
            end
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                if (wr_hi_en) hi_q <= wr_data;
                if (wr_lo_en) lo_q <= wr_data;
            end
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign stall = busy && (start || rd_req || wr_hi || wr_lo);

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: each issued operation pushes its
// expected {hi, lo}; a monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] num_1 = '0;
    logic [31:0] num_2 = '0;
    logic        rd_req = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mult_div_unit #(.LEN(32), .LEN_CNT(6)) dut (
        .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
        .num_1(num_1), .num_2(num_2), .rd_req(rd_req), .wr_hi(wr_hi),
        .wr_lo(wr_lo), .wr_data(wr_data), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (reset && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no result", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", hi, e[63:32]);
                check("result_lo", lo, e[31:0]);
            end
        end
    end

    // Issue one op and watch 36 cycles: latency, busy width, done width.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        int lat, nb, nd;
        lat = 0; nb = 0; nd = 0;
        @(negedge clk);
        start = 1'b1; op = o; num_1 = a; num_2 = b;
        exp_q.push_back({eh, el});
        #1 check("stall_on_start", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                if (lat == 0) lat = k;
            end
        end
        check("done_latency", 32'(lat), 32'd34);
        check("busy_cycles", 32'(nb), 32'd33);
        check("done_width", 32'(nd), 32'd1);
    endtask

    initial begin
        int n, nd;
        // Reset state
        #2;
        start = 1'b1; rd_req = 1'b1;
        #1;
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        start = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

        // MULT -3 x 7 followed by a dependent MFHI
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; num_1 = 32'hFFFFFFFD; num_2 = 32'd7;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
        @(negedge clk);
        start = 1'b0; rd_req = 1'b1;
        n = 0;
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            #1 if (stall) n++;
        end
        check("mfhi_stall_cycles", 32'(n), 32'd33);
        @(negedge clk);
        #1;
        check("mfhi_stall_release", 32'(stall), 32'd0);
        check("mfhi_hi", hi, 32'hFFFFFFFF);
        check("mfhi_lo", lo, 32'hFFFFFFEB);
        rd_req = 1'b0;

        run_op(MDU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op(MDU_DIVU, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF);
        run_op(MDU_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        run_op(MDU_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op(MDU_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001);
        run_op(MDU_MULTU, 32'h12345678, 32'h10,      32'h00000001, 32'h23456780);

        // MTHI in IDLE
        @(negedge clk);
        wr_hi = 1'b1; wr_data = 32'h12345678;
        @(negedge clk);
        wr_hi = 1'b0;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo", lo, 32'h23456780);
        check("mthi_done", 32'(done), 32'd0);

        // MTLO while busy is held until IDLE
        @(negedge clk);
        start = 1'b1; op = MDU_MULTU; num_1 = 32'd3; num_2 = 32'd4;
        exp_q.push_back(64'h00000000_0000000C);
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b1; wr_data = 32'hCAFEF00D;
        #1 check("mtlo_busy_stall", 32'(stall), 32'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1 if (!stall) break;
            n++;
        end
        check("mtlo_stall_cycles", 32'(n), 32'd32);
        check("mtlo_lo_before", lo, 32'h0000000C);
        @(negedge clk);
        wr_lo = 1'b0;
        check("mtlo_lo_after", lo, 32'hCAFEF00D);
        check("mtlo_hi_after", hi, 32'h0);

        // Flush abort at t+10
        @(negedge clk);
        start = 1'b1; op = MDU_MULTU; num_1 = 32'd5; num_2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("flush_no_done", 32'(nd), 32'd0);
        check("flush_hi", hi, 32'h0);
        check("flush_lo", lo, 32'hCAFEF00D);

        // Reset abort at t+10
        @(negedge clk);
        start = 1'b1; op = MDU_MULTU; num_1 = 32'd5; num_2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_abort_hi", hi, 32'h0);
        check("rst_abort_lo", lo, 32'h0);
        check("rst_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        check("rst_abort_idle", 32'(nd), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
